// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle sequencer and its datapath.
// The master modport belongs to the controller; the datapath uses slave.
interface multicycle_controller_if;
  logic [31:0] instr;
  logic        zero;
  logic        less_signed;
  logic        less_unsigned;
  logic        mem_ready;
  logic        pc_write;
  logic        ir_write;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        adr_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  result_src;
  logic [3:0]  alu_control;
  logic [2:0]  imm_src;
  logic [2:0]  data_control;
  logic        instr_retired;
  logic        fault;
  logic [3:0]  state;

  modport master (
    input  instr, zero, less_signed, less_unsigned, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
           alu_src_a, alu_src_b, result_src, alu_control, imm_src,
           data_control, instr_retired, fault, state
  );

  modport slave (
    output instr, zero, less_signed, less_unsigned, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
           alu_src_a, alu_src_b, result_src, alu_control, imm_src,
           data_control, instr_retired, fault, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and drives all enables and selects.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_JAL = 4'd9, S_JALR = 4'd10, S_BRANCH = 4'd11,
    S_EXECU = 4'd12, S_FAULT = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_R     = 7'b0110011, OP_I     = 7'b0010011,
                         OP_BR    = 7'b1100011, OP_JAL   = 7'b1101111,
                         OP_JALR  = 7'b1100111, OP_LUI   = 7'b0110111,
                         OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                         ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLL = 4'd5,
                         ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8,
                         ALU_SLTU = 4'd9, ALU_PASSB = 4'd10;

  localparam logic [15:0] TIMEOUT_LAST =
    (MEM_TIMEOUT == 0) ? 16'd0 : 16'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        fault_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       waiting;
  logic       timeout_hit;
  logic       taken;

  assign opcode   = bus.instr[6:0];
  assign funct3   = bus.instr[14:12];
  assign funct7b5 = bus.instr[30];

  assign waiting = (state_q == S_FETCH || state_q == S_MEMREAD ||
                    state_q == S_MEMWRITE) && !bus.mem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && (wait_q == TIMEOUT_LAST);

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    case (funct3)
      3'b000:  taken = bus.zero;
      3'b001:  taken = !bus.zero;
      3'b100:  taken = bus.less_signed;
      3'b101:  taken = !bus.less_signed;
      3'b110:  taken = bus.less_unsigned;
      3'b111:  taken = !bus.less_unsigned;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    wait_d  = waiting ? 16'(wait_q + 16'd1) : 16'd0;
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (timeout_hit) state_d = S_FAULT;
                  else if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = (funct3[2:1] == 2'b01) ? S_FAULT : S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_EXECU;
          default:           state_d = S_FAULT;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (timeout_hit) state_d = S_FAULT;
                  else if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (timeout_hit) state_d = S_FAULT;
                  else if (bus.mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_EXECU: state_d = S_ALUWB;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      default:    state_d = S_FAULT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_d == S_FAULT) fault_q <= 1'b1;
    end
  end

  logic       pc_write, ir_write, reg_write, mem_read, mem_write, adr_src, retired;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_control;
  logic [2:0] imm_src, data_control;

  // NOTE: every output gets a default up front so no path through the case
  // leaves a variable unassigned and infers a latch.
  always_comb begin
    pc_write = 1'b0; ir_write = 1'b0; reg_write = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; adr_src = 1'b0; retired = 1'b0;
    alu_src_a = 2'b00; alu_src_b = 2'b00; result_src = 2'b00;
    alu_control = ALU_ADD; data_control = 3'b000;
    case (opcode)
      OP_STORE:         imm_src = 3'b001;
      OP_BR:            imm_src = 3'b010;
      OP_JAL:           imm_src = 3'b011;
      OP_LUI, OP_AUIPC: imm_src = 3'b100;
      default:          imm_src = 3'b000;
    endcase
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1; pc_write = 1'b1;
          alu_src_b = 2'b10; result_src = 2'b10;
        end
      end
      S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      S_MEMREAD:  begin adr_src = 1'b1; mem_read = 1'b1; data_control = funct3; end
      S_MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; retired = 1'b1;
                        data_control = funct3; end
      S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; data_control = funct3;
                        retired = bus.mem_ready; end
      S_EXECR:    begin alu_src_a = 2'b10; alu_control = alu_decode(funct3, funct7b5); end
      S_EXECI: begin
        alu_src_a = 2'b10; alu_src_b = 2'b01;
        alu_control = alu_decode(funct3, funct7b5 && (funct3 == 3'b101));
      end
      S_EXECU: begin
        alu_src_b = 2'b01;
        if (opcode == OP_LUI) alu_control = ALU_PASSB;
        else alu_src_a = 2'b01;
      end
      S_ALUWB:    begin reg_write = 1'b1; retired = 1'b1; end
      S_JALR:     begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
      S_BRANCH: begin
        alu_src_a = 2'b10; alu_control = ALU_SUB;
        pc_write = taken; retired = 1'b1;
      end
      default: ;
    endcase
    // Reset overrides combinationally so an access in flight drops at once.
    if (rst) begin
      pc_write = 1'b0; ir_write = 1'b0; reg_write = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; adr_src = 1'b0; retired = 1'b0;
      alu_src_a = 2'b00; alu_src_b = 2'b00; result_src = 2'b00;
      alu_control = ALU_ADD; imm_src = 3'b000; data_control = 3'b000;
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.ir_write      = ir_write;
  assign bus.reg_write     = reg_write;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.adr_src       = adr_src;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.result_src    = result_src;
  assign bus.alu_control   = alu_control;
  assign bus.imm_src       = imm_src;
  assign bus.data_control  = data_control;
  assign bus.instr_retired = retired;
  assign bus.fault         = fault_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an instruction-level model builds
// the expected per-cycle control word; one compare routine checks every cycle.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if bus();
  multicycle_controller #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, rw, mrd, mwr, adr;
    logic [1:0] a, b, rs;
    logic [3:0] alu;
    logic [2:0] imm, dc;
    logic       ret, flt;
  } exp_t;

  localparam logic [3:0] ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3,
                         ST_MEMWB = 4, ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7,
                         ST_ALUWB = 8, ST_JAL = 9, ST_JALR = 10, ST_BRANCH = 11,
                         ST_EXECU = 12, ST_FAULT = 15;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];
  logic mr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic exp_t actual();
    exp_t e;
    e.st = bus.state; e.pcw = bus.pc_write; e.irw = bus.ir_write;
    e.rw = bus.reg_write; e.mrd = bus.mem_read; e.mwr = bus.mem_write;
    e.adr = bus.adr_src; e.a = bus.alu_src_a; e.b = bus.alu_src_b;
    e.rs = bus.result_src; e.alu = bus.alu_control; e.imm = bus.imm_src;
    e.dc = bus.data_control; e.ret = bus.instr_retired; e.flt = bus.fault;
    return e;
  endfunction

  function automatic exp_t blank(input logic [3:0] st, input logic [2:0] imm);
    exp_t e = '0;
    e.st = st; e.imm = imm;
    return e;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0100011:             return 3'd1;
      7'b1100011:             return 3'd2;
      7'b1101111:             return 3'd3;
      7'b0110111, 7'b0010111: return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

  // funct3 -> operation name table from the instruction set.
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] tbl [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    if (alt && f3 == 3'b000) return 4'd1;
    if (alt && f3 == 3'b101) return 4'd7;
    return tbl[f3];
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic z, input logic ls,
                                    input logic lu);
    case (f3)
      3'd0: return z;   3'd1: return !z;
      3'd4: return ls;  3'd5: return !ls;
      3'd6: return lu;  default: return !lu;
    endcase
  endfunction

  task automatic push(input exp_t e, input logic mr);
    exp_q.push_back(e);
    mr_q.push_back(mr);
  endtask

  task automatic push_wb(input logic [2:0] imm);
    exp_t e = blank(ST_ALUWB, imm);
    e.rw = 1; e.ret = 1;
    push(e, 1);
  endtask

  // Expected cycle-by-cycle trace of one instruction from its class.
  task automatic build(input logic [31:0] ins, input int fw, input int mw,
                       input logic z, input logic ls, input logic lu);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic       f7 = ins[30];
    logic [2:0] imm = imm_of(op);
    exp_t e;
    e = blank(ST_FETCH, imm); e.mrd = 1;
    repeat (fw) push(e, 0);
    e.irw = 1; e.pcw = 1; e.b = 2; e.rs = 2; push(e, 1);
    e = blank(ST_DECODE, imm); e.a = 1; e.b = 1; push(e, 1);
    case (op)
      7'b0000011, 7'b0100011: begin
        e = blank(ST_MEMADR, imm); e.a = 2; e.b = 1; push(e, 1);
        if (op == 7'b0000011) begin
          e = blank(ST_MEMREAD, imm); e.adr = 1; e.mrd = 1; e.dc = f3;
          repeat (mw) push(e, 0);
          push(e, 1);
          e = blank(ST_MEMWB, imm); e.rs = 1; e.rw = 1; e.ret = 1; e.dc = f3; push(e, 1);
        end else begin
          e = blank(ST_MEMWRITE, imm); e.adr = 1; e.mwr = 1; e.dc = f3;
          repeat (mw) push(e, 0);
          e.ret = 1; push(e, 1);
        end
      end
      7'b0110011: begin
        e = blank(ST_EXECR, imm); e.a = 2; e.alu = alu_of(f3, f7); push(e, 1);
        push_wb(imm);
      end
      7'b0010011: begin
        e = blank(ST_EXECI, imm); e.a = 2; e.b = 1; e.alu = alu_of(f3, f7 && f3 == 3'd5);
        push(e, 1); push_wb(imm);
      end
      7'b0110111, 7'b0010111: begin
        e = blank(ST_EXECU, imm); e.b = 1;
        if (op == 7'b0110111) e.alu = 4'd10; else e.a = 1;
        push(e, 1); push_wb(imm);
      end
      7'b1101111, 7'b1100111: begin
        if (op == 7'b1100111) begin
          e = blank(ST_JALR, imm); e.a = 2; e.b = 1; push(e, 1);
        end
        e = blank(ST_JAL, imm); e.a = 1; e.b = 2; e.pcw = 1; push(e, 1);
        push_wb(imm);
      end
      default: begin
        if (op == 7'b1100011 && f3 != 3'd2 && f3 != 3'd3) begin
          e = blank(ST_BRANCH, imm); e.a = 2; e.alu = 4'd1; e.ret = 1;
          e.pcw = taken_of(f3, z, ls, lu); push(e, 1);
        end else begin
          e = blank(ST_FAULT, imm); e.flt = 1;
          push(e, 1); push(e, 1);
        end
      end
    endcase
  endtask

  // Plays queued steps (up to max_steps); returns the step of first retire.
  task automatic play(input string name, input logic [31:0] ins, input logic z,
                      input logic ls, input logic lu, input int max_steps,
                      output int ret_at);
    int k = 0;
    ret_at = 0;
    while (exp_q.size() > 0 && k < max_steps) begin
      @(posedge clk); #1;
      bus.instr = ins; bus.zero = z; bus.less_signed = ls; bus.less_unsigned = lu;
      bus.mem_ready = mr_q.pop_front();
      @(negedge clk);
      k++;
      if (bus.instr_retired === 1'b1 && ret_at == 0) ret_at = k;
      check($sformatf("%s_c%0d", name, k), 32'(actual()), 32'(exp_q.pop_front()));
    end
    exp_q.delete();
    mr_q.delete();
  endtask

  task automatic run(input string name, input logic [31:0] ins, input int fw, input int mw,
                     input logic z, input logic ls, input logic lu, output int ret_at);
    build(ins, fw, mw, z, ls, lu);
    play(name, ins, z, ls, lu, 1000, ret_at);
  endtask

  task automatic pulse_reset(input string name);
    exp_t e;
    @(posedge clk); #3;
    rst = 1'b1; #1;
    check({name, "_in_rst"}, 32'(actual()), 32'(blank(ST_FETCH, 3'd0)));
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    e = blank(ST_FETCH, imm_of(bus.instr[6:0])); e.mrd = 1;
    check({name, "_released"}, 32'(actual()), 32'(e));
  endtask

  int cyc;
  exp_t e;

  initial begin
    bus.instr = 32'h0; bus.zero = 0; bus.less_signed = 0; bus.less_unsigned = 0;
    bus.mem_ready = 0;
    #12;
    check("reset_state", 32'(actual()), 32'(blank(ST_FETCH, 3'd0)));
    @(posedge clk); #1; rst = 1'b0;

    run("add", 32'h002081B3, 0, 0, 0, 0, 0, cyc);
    check("add_cycles", cyc, 4);
    run("sub_fwait", 32'h402081B3, 1, 0, 0, 0, 0, cyc);
    check("sub_cycles", cyc, 5);
    run("lw", 32'h00802283, 0, 2, 0, 0, 0, cyc);
    check("lw_cycles", cyc, 7);
    run("bne_z1", 32'h00209463, 0, 0, 1, 0, 0, cyc);
    check("bne_z1_cycles", cyc, 3);
    run("bne_z0", 32'h00209463, 0, 0, 0, 0, 0, cyc);
    check("bne_z0_cycles", cyc, 3);
    run("blt", 32'h0020C463, 0, 0, 0, 1, 0, cyc);
    run("bgeu", 32'h0020F463, 0, 0, 0, 0, 1, cyc);
    run("srai", 32'h4030D093, 0, 0, 0, 0, 0, cyc);
    run("addi_b30", 32'h40008093, 0, 0, 0, 0, 0, cyc);
    run("sw", 32'h0051A423, 0, 1, 0, 0, 0, cyc);
    check("sw_cycles", cyc, 5);
    run("jal", 32'h008000EF, 0, 0, 0, 0, 0, cyc);
    check("jal_cycles", cyc, 4);
    run("jalr", 32'h000080E7, 0, 0, 0, 0, 0, cyc);
    check("jalr_cycles", cyc, 5);
    run("lui", 32'h123452B7, 0, 0, 0, 0, 0, cyc);
    run("auipc", 32'h00001297, 0, 0, 0, 0, 0, cyc);

    run("illegal", 32'h0000007F, 0, 0, 0, 0, 0, cyc);
    check("illegal_no_retire", cyc, 0);
    check("illegal_fault", 32'(bus.fault), 32'd1);
    pulse_reset("illegal_rst");
    check("fault_cleared", 32'(bus.fault), 32'd0);

    run("after_rst", 32'h002081B3, 0, 0, 0, 0, 0, cyc);
    run("bad_branch", 32'h0020A463, 0, 0, 0, 0, 0, cyc);
    pulse_reset("badbr_rst");
    run("add2", 32'h002081B3, 0, 0, 0, 0, 0, cyc);

    // Memory never answers: four fetch wait cycles, then fault.
    e = blank(ST_FETCH, 3'd0); e.mrd = 1;
    repeat (4) push(e, 0);
    e = blank(ST_FAULT, 3'd0); e.flt = 1;
    push(e, 0); push(e, 0);
    play("timeout", 32'h002081B3, 0, 0, 0, 1000, cyc);
    pulse_reset("timeout_rst");
    run("add3", 32'h002081B3, 0, 0, 0, 0, 0, cyc);

    // Reset in the middle of a store that is still waiting for memory.
    build(32'h0051A423, 0, 3, 0, 0, 0);
    play("sw_cut", 32'h0051A423, 0, 0, 0, 4, cyc);
    #2;
    check("sw_cut_mwr_before", 32'(bus.mem_write), 32'd1);
    pulse_reset("sw_cut_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
